// File: rtl/led_debug_sequencer_if.sv
// Avalon-MM slave bus of the LED debug sequencer: word address, select,
// active-low write strobe and zero-wait-state combinational read data.
interface led_debug_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_debug_sequencer.sv
// Debug LED driver: shows a PIO request bit directly, stretched, or as a
// repeating blink code, with a programmable tick prescaler and sticky edge flag.
module led_debug_sequencer #(
  parameter int                DIV_W       = 24,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV = 24'd49999,
  parameter int                ON_TICKS    = 2,
  parameter int                OFF_TICKS   = 2,
  parameter int                GAP_TICKS   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pio_in,
  led_debug_sequencer_if.slave  bus,
  output logic                  led_out
);

  localparam logic [1:0] MODE_DIRECT  = 2'd0;
  localparam logic [1:0] MODE_STRETCH = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;

  localparam logic [15:0] ON_T  = 16'(ON_TICKS);
  localparam logic [15:0] OFF_T = 16'(OFF_TICKS);
  localparam logic [15:0] GAP_T = 16'(GAP_TICKS);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} state_t;

  logic [1:0]        mode_reg;
  logic              invert_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [3:0]        n_reg;
  logic [7:0]        s_reg;
  logic              pio_q_reg;
  logic [DIV_W-1:0]  presc_reg, presc_next;
  logic [7:0]        stretch_reg, stretch_next;
  logic              sticky_reg, sticky_next;
  logic              led_out_reg;
  state_t            state_reg, state_next;
  logic [15:0]       phase_reg, phase_next;
  logic [3:0]        remaining_reg, remaining_next;

  logic              wr_en;
  logic [3:0]        wr_sel;
  logic              mode_change;
  logic              rise;
  logic              tick;
  logic              busy;
  logic              raw;
  logic              unused_wdata;

  assign wr_en = bus.chipselect && !bus.write_n;

  // One write enable per implemented register; addresses 4-7 decode to nothing.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en && (bus.address == 3'(gi));
  end

  assign mode_change  = wr_sel[0] && (bus.writedata[1:0] != mode_reg);
  assign rise         = pio_in && !pio_q_reg;
  assign tick         = (presc_reg >= div_reg);
  assign busy         = (state_reg != ST_IDLE) || (stretch_reg != 8'd0);
  assign led_out      = led_out_reg;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    presc_next = presc_reg + 1'b1;
    if (mode_change || wr_sel[1] || tick)
      presc_next = '0;
  end

  // Stretch reload wins over a same-cycle tick so a retrigger always restarts at S.
  always_comb begin
    stretch_next = stretch_reg;
    if (mode_change)
      stretch_next = 8'd0;
    else if (mode_reg == MODE_STRETCH && rise)
      stretch_next = s_reg;
    else if (tick && stretch_reg != 8'd0)
      stretch_next = stretch_reg - 8'd1;
  end

  assign sticky_next = rise | (sticky_reg & ~(wr_sel[3] & bus.writedata[2]));

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    remaining_next = remaining_reg;
    if (mode_change || mode_reg != MODE_BLINK) begin
      state_next     = ST_IDLE;
      phase_next     = 16'd0;
      remaining_next = 4'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pio_q_reg && n_reg != 4'd0) begin
            state_next     = ST_ON;
            phase_next     = ON_T;
            remaining_next = n_reg;
          end
        end
        ST_ON: begin
          if (tick) begin
            if (phase_reg <= 16'd1) begin
              state_next     = ST_OFF;
              phase_next     = OFF_T;
              remaining_next = remaining_reg - 4'd1;
            end else begin
              phase_next = phase_reg - 16'd1;
            end
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (phase_reg <= 16'd1) begin
              if (remaining_reg != 4'd0) begin
                state_next = ST_ON;
                phase_next = ON_T;
              end else begin
                state_next = ST_GAP;
                phase_next = GAP_T;
              end
            end else begin
              phase_next = phase_reg - 16'd1;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (phase_reg <= 16'd1) begin
              if (pio_q_reg && n_reg != 4'd0) begin
                state_next     = ST_ON;
                phase_next     = ON_T;
                remaining_next = n_reg;
              end else begin
                state_next = ST_IDLE;
                phase_next = 16'd0;
              end
            end else begin
              phase_next = phase_reg - 16'd1;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          phase_next = 16'd0;
        end
      endcase
    end
  end

  always_comb begin
    case (mode_reg)
      MODE_DIRECT:  raw = pio_q_reg;
      MODE_STRETCH: raw = (stretch_reg != 8'd0);
      MODE_BLINK:   raw = (state_reg == ST_ON);
      default:      raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg      <= 2'd0;
      invert_reg    <= 1'b0;
      div_reg       <= DEFAULT_DIV;
      n_reg         <= 4'd0;
      s_reg         <= 8'd0;
      pio_q_reg     <= 1'b0;
      presc_reg     <= '0;
      stretch_reg   <= 8'd0;
      sticky_reg    <= 1'b0;
      led_out_reg   <= 1'b0;
      state_reg     <= ST_IDLE;
      phase_reg     <= 16'd0;
      remaining_reg <= 4'd0;
    end else begin
      if (wr_sel[0]) begin
        mode_reg   <= bus.writedata[1:0];
        invert_reg <= bus.writedata[2];
      end
      if (wr_sel[1])
        div_reg <= bus.writedata[DIV_W-1:0];
      if (wr_sel[2]) begin
        n_reg <= bus.writedata[3:0];
        s_reg <= bus.writedata[15:8];
      end
      pio_q_reg     <= pio_in;
      presc_reg     <= presc_next;
      stretch_reg   <= stretch_next;
      sticky_reg    <= sticky_next;
      led_out_reg   <= raw ^ invert_reg;
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      3'd0: bus.readdata[2:0] = {invert_reg, mode_reg};
      3'd1: bus.readdata[DIV_W-1:0] = div_reg;
      3'd2: begin
        bus.readdata[3:0]  = n_reg;
        bus.readdata[15:8] = s_reg;
      end
      3'd3: bus.readdata[7:0] = {remaining_reg, 1'b0, sticky_reg, busy, led_out_reg};
      default: bus.readdata = 32'd0;
    endcase
  end

endmodule
